// File: rtl/fnd_pkg.sv
// Shared types and constants for the two-digit seven-segment scanner:
// FSM states, active-low segment codes, and the double-dabble step helpers.
package fnd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  // Active-low {g,f,e,d,c,b,a} codes for the decimal digits
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [2:0] CONV_STEPS = 3'd7;

  function automatic logic [6:0] clamp99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  // One double-dabble step on {tens, ones, binary[6:0]}: adjust then shift
  function automatic logic [14:0] dd_step(input logic [14:0] s);
    logic [14:0] a;
    a = s;
    a[10:7]  = (a[10:7]  >= 4'd5) ? (a[10:7]  + 4'd3) : a[10:7];
    a[14:11] = (a[14:11] >= 4'd5) ? (a[14:11] + 4'd3) : a[14:11];
    return {a[13:0], 1'b0};
  endfunction

endpackage

// File: rtl/fnd_decoder.sv
// Combinational 4-bit to active-low 7-segment mapping; blank forces all
// segments off, and out-of-range nibbles also decode as blank.
module fnd_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);

  // Digit lookup with blank override
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (nib)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/fnd_scan_100.sv
// Two-digit display driver: converts a 0..99 count to BCD with a serial
// double-dabble FSM and time-multiplexes the two digits onto one segment bus.
module fnd_scan_100 #(
  parameter int unsigned P_SCAN_DIV = 1000,
  parameter bit          P_BLANK_LZ = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] i_cnt,
  output logic [7:0] o_bcd,
  output logic       o_ovf,
  output logic       o_busy,
  output logic [1:0] o_com,
  output logic [6:0] o_seg
);
  import fnd_pkg::*;

  localparam logic [15:0] DIV_LAST = 16'(P_SCAN_DIV - 1);

  state_t      state;
  logic [6:0]  r_cnt_q;
  logic [6:0]  r_disp_bin;
  logic [6:0]  snap;
  logic        ovf_snap;
  logic [14:0] sreg;
  logic [2:0]  step_cnt;
  logic [15:0] div;
  logic        tc;
  logic        next_tens;
  logic        blank;
  logic [3:0]  nib;
  logic [6:0]  dec_seg;

  // Input capture and conversion FSM
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      r_cnt_q    <= 7'd0;
      r_disp_bin <= 7'd0;
      snap       <= 7'd0;
      ovf_snap   <= 1'b0;
      sreg       <= 15'd0;
      step_cnt   <= 3'd0;
      o_bcd      <= 8'h00;
      o_ovf      <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      r_cnt_q <= i_cnt;
      case (state)
        ST_IDLE: begin
          if (r_cnt_q != r_disp_bin) begin
            snap     <= r_cnt_q;
            ovf_snap <= (r_cnt_q > 7'd99);
            sreg     <= {8'h00, clamp99(r_cnt_q)};
            step_cnt <= 3'd0;
            o_busy   <= 1'b1;
            state    <= ST_CONV;
          end else begin
            o_busy   <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_CONV: begin
          sreg     <= dd_step(sreg);
          step_cnt <= step_cnt + 3'd1;
          o_busy   <= 1'b1;
          if (step_cnt == CONV_STEPS - 3'd1) begin
            state <= ST_UPDATE;
          end else begin
            state <= ST_CONV;
          end
        end
        ST_UPDATE: begin
          // Display register takes the clamped BCD; compare value stays unclamped
          o_bcd      <= sreg[14:7];
          o_ovf      <= ovf_snap;
          r_disp_bin <= snap;
          o_busy     <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Select the digit that will be active after this edge and its segment source
  always_comb begin
    tc        = (div == DIV_LAST);
    next_tens = tc ? o_com[1] : ~o_com[1];
    nib       = next_tens ? o_bcd[7:4] : o_bcd[3:0];
    blank     = next_tens && (P_BLANK_LZ != 1'b0) && (o_bcd[7:4] == 4'd0);
  end

  fnd_decoder u_decoder (
    .nib   (nib),
    .blank (blank),
    .seg   (dec_seg)
  );

  // Scan divider and registered digit enables / segments
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div   <= 16'd0;
      o_com <= 2'b10;
      o_seg <= SEG_0;
    end else begin
      div   <= tc ? 16'd0 : (div + 16'd1);
      o_com <= next_tens ? 2'b01 : 2'b10;
      o_seg <= dec_seg;
    end
  end

endmodule
